// File: rtl/game_pkg.sv
// Shared state/screen encoding for the game sequencer. State values double as
// the screen and sound codes, so the screen output is the state register itself.
package game_pkg;

  typedef enum logic [2:0] {
    TITLE  = 3'd0,
    PLAY   = 3'd1,
    LOSE   = 3'd2,
    WIN    = 3'd3,
    LVL_UP = 3'd4,
    WLD_UP = 3'd5,
    PAUSE  = 3'd6,
    DEAD   = 3'd7
  } state_t;

  localparam logic [2:0] SCR_TITLE  = 3'd0;
  localparam logic [2:0] SCR_PLAY   = 3'd1;
  localparam logic [2:0] SCR_LOSE   = 3'd2;
  localparam logic [2:0] SCR_WIN    = 3'd3;
  localparam logic [2:0] SCR_LVL_UP = 3'd4;
  localparam logic [2:0] SCR_WLD_UP = 3'd5;
  localparam logic [2:0] SCR_PAUSE  = 3'd6;
  localparam logic [2:0] SCR_DEAD   = 3'd7;
  localparam logic [2:0] SND_SILENT = 3'd0;

  // States that play a one-shot audio sequence and wait for the player.
  function automatic logic isEvent(input state_t s);
    return (s == DEAD) || (s == LVL_UP) || (s == WLD_UP) ||
           (s == LOSE) || (s == WIN);
  endfunction

  // Thermometer code: bit i set when count > i.
  function automatic logic [7:0] thermo(input logic [3:0] count);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) begin
      t[i] = (count > 4'(i));
    end
    return t;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a level-sensitive button: one-cycle press strobe.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic btnPrev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) btnPrev <= 1'b0;
    else     btnPrev <= btn;
  end

  assign press = btn & ~btnPrev;

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: title/play/pause plus event screens that wait for the
// audio sequence to finish before accepting the player's continue/start.
module game_sequencer
  import game_pkg::*;
#(
  parameter int NUM_WORLDS       = 3,
  parameter int LEVELS_PER_WORLD = 4,
  parameter int MAX_LIVES        = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       continue_btn,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       player_dead,
  input  logic       level_complete,
  input  logic       seq_end,
  output logic [2:0] level,
  output logic [2:0] world,
  output logic [2:0] screen,
  output logic [7:0] lives,
  output logic       player_disable,
  output logic       reset_select,
  output logic [2:0] audio_select,
  output logic       audio_enable
);

  localparam logic [2:0] LAST_LEVEL = 3'(LEVELS_PER_WORLD - 1);
  localparam logic [2:0] LAST_WORLD = 3'(NUM_WORLDS - 1);
  localparam logic [3:0] LIVES_INIT = 4'(MAX_LIVES);

  logic startPress, pausePress, contPress;

  btn_edge uStartEdge (.clk(clk), .rst(rst), .btn(start_btn),    .press(startPress));
  btn_edge uPauseEdge (.clk(clk), .rst(rst), .btn(pause_btn),    .press(pausePress));
  btn_edge uContEdge  (.clk(clk), .rst(rst), .btn(continue_btn), .press(contPress));

  state_t     state, stateNxt;
  logic [2:0] levelNxt, worldNxt;
  logic [3:0] livesCnt, livesCntNxt;
  logic       seqDone, seqDoneNxt;
  logic       resetSelNxt;

  always_comb begin
    stateNxt    = state;
    levelNxt    = level;
    worldNxt    = world;
    livesCntNxt = livesCnt;
    seqDoneNxt  = seqDone;
    resetSelNxt = 1'b0;
    case (state)
      TITLE: begin
        if (startPress) begin
          stateNxt    = PLAY;
          livesCntNxt = LIVES_INIT;
          levelNxt    = 3'd0;
          worldNxt    = 3'd0;
          resetSelNxt = 1'b1;
        end
      end
      PLAY: begin
        // Reaching the goal outranks a simultaneous death.
        if (level_complete) begin
          seqDoneNxt = 1'b0;
          if (level != LAST_LEVEL) begin
            stateNxt = LVL_UP;
            levelNxt = level + 3'd1;
          end else if (world != LAST_WORLD) begin
            stateNxt = WLD_UP;
            worldNxt = world + 3'd1;
            levelNxt = 3'd0;
          end else begin
            stateNxt = WIN;
          end
        end else if (player_dead) begin
          seqDoneNxt = 1'b0;
          if (livesCnt > 4'd1) begin
            stateNxt    = DEAD;
            livesCntNxt = livesCnt - 4'd1;
          end else begin
            stateNxt    = LOSE;
            livesCntNxt = 4'd0;
          end
        end else if (pausePress) begin
          stateNxt = PAUSE;
        end
      end
      PAUSE: begin
        if (pausePress) stateNxt = PLAY;
      end
      DEAD, LVL_UP, WLD_UP: begin
        if (seqDone && contPress) begin
          stateNxt    = PLAY;
          resetSelNxt = 1'b1;
        end else if (seq_end) begin
          seqDoneNxt = 1'b1;
        end
      end
      LOSE, WIN: begin
        if (seqDone && startPress) begin
          stateNxt = TITLE;
        end else if (seq_end) begin
          seqDoneNxt = 1'b1;
        end
      end
      default: stateNxt = TITLE;
    endcase
  end

  // All outputs are derived from next-state values and registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= TITLE;
      level          <= 3'd0;
      world          <= 3'd0;
      livesCnt       <= LIVES_INIT;
      lives          <= thermo(LIVES_INIT);
      seqDone        <= 1'b0;
      player_disable <= 1'b1;
      reset_select   <= 1'b0;
      audio_select   <= SND_SILENT;
      audio_enable   <= 1'b0;
    end else begin
      state          <= stateNxt;
      level          <= levelNxt;
      world          <= worldNxt;
      livesCnt       <= livesCntNxt;
      lives          <= thermo(livesCntNxt);
      seqDone        <= seqDoneNxt;
      player_disable <= (stateNxt != PLAY);
      reset_select   <= resetSelNxt;
      audio_select   <= ((stateNxt == PLAY) || (stateNxt == PAUSE)) ? SND_SILENT : 3'(stateNxt);
      audio_enable   <= isEvent(stateNxt) && !seqDoneNxt;
    end
  end

  assign screen = 3'(state);

endmodule
